// File: rtl/isp_geom_pkg.sv
// Shared padded-raster geometry helpers and state encoding for the filter border stages.
package isp_geom_pkg;

  localparam int unsigned PIX_W = 24;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {IDLE, LEAD, GRID} geom_state_e;

  function automatic int unsigned border(input int unsigned ksize);
    return (ksize - 1) / 2;
  endfunction

  function automatic int unsigned pad_w(input int unsigned w, input int unsigned ksize);
    return w + 2 * border(ksize);
  endfunction

  function automatic int unsigned pad_h(input int unsigned h, input int unsigned ksize);
    return h + 2 * border(ksize);
  endfunction

  function automatic int unsigned total_beats(input int unsigned w, input int unsigned h,
                                              input int unsigned ksize, input int unsigned lead);
    return pad_w(w, ksize) * pad_h(h, ksize) + lead;
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Column/row position counter over a cols x rows raster; clr restarts at (0,0) and may
// coincide with inc, in which case the incoming beat is counted at (0,0).
module raster_counter
  import isp_geom_pkg::*;
#(
  parameter int unsigned cols = 6,
  parameter int unsigned rows = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] col,
  output logic [CNT_W-1:0] row,
  output logic             last
);

  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(cols - 1);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(rows - 1);

  logic [CNT_W-1:0] col_q, col_d, row_q, row_d, col_b, row_b;

  always_comb begin
    col_b = clr ? '0 : col_q;
    row_b = clr ? '0 : row_q;
    col_d = col_b;
    row_d = row_b;
    if (inc) begin
      if (col_b == COL_LAST) begin
        col_d = '0;
        row_d = (row_b == ROW_LAST) ? '0 : row_b + 1'b1;
      end else begin
        col_d = col_b + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col  = col_q;
  assign row  = row_q;
  assign last = (col_q == COL_LAST) && (row_q == ROW_LAST);

endmodule

// File: rtl/filter_unpad.sv
// Strips border/pipeline-fill beats from the padded filter output stream and emits interior
// pixels with coordinates. Optional FILTER_UNPAD_CHECKSUM_EN adds a per-frame oChecksum.
module filter_unpad
  import isp_geom_pkg::*;
#(
  parameter int unsigned width       = 320,
  parameter int unsigned height      = 240,
  parameter int unsigned kernelSize  = 3,
  parameter int unsigned leadDiscard = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             newFrame,
  input  logic             iValid,
  input  logic [PIX_W-1:0] iData,
  output logic             oValid,
  output logic [PIX_W-1:0] oData,
  output logic [CNT_W-1:0] oX,
  output logic [CNT_W-1:0] oY,
  output logic             oDone,
`ifdef FILTER_UNPAD_CHECKSUM_EN
  output logic [31:0]      oChecksum,
`endif
  output logic             oAbort
);

  localparam int unsigned      B         = border(kernelSize);
  localparam int unsigned      PW        = pad_w(width, kernelSize);
  localparam int unsigned      PH        = pad_h(height, kernelSize);
  localparam logic [CNT_W-1:0] B16       = CNT_W'(B);
  localparam logic [CNT_W-1:0] XEND      = CNT_W'(B + width);
  localparam logic [CNT_W-1:0] YEND      = CNT_W'(B + height);
  localparam logic [CNT_W-1:0] XLAST     = CNT_W'(B + width - 1);
  localparam logic [CNT_W-1:0] YLAST     = CNT_W'(B + height - 1);
  localparam logic [CNT_W-1:0] LEAD_LAST = CNT_W'((leadDiscard > 0) ? leadDiscard - 1 : 0);

  geom_state_e      state_q, state_d;
  logic [CNT_W-1:0] lead_q, lead_d;
  logic [CNT_W-1:0] col, row;
  logic             last, final_beat, grid_inc, grid_clr, abort, interior;

  logic             oValid_q, oDone_q, oAbort_q;
  logic [PIX_W-1:0] oData_q;
  logic [CNT_W-1:0] oX_q, oY_q;

  raster_counter #(.cols(PW), .rows(PH)) u_raster (
    .clk  (clk),
    .reset(reset),
    .inc  (grid_inc),
    .clr  (grid_clr),
    .col  (col),
    .row  (row),
    .last (last)
  );

  assign final_beat = (state_q == GRID) && iValid && last;

  // newFrame coinciding with the final grid beat lets that beat finish and just re-arms.
  always_comb begin
    state_d  = state_q;
    lead_d   = lead_q;
    grid_inc = 1'b0;
    grid_clr = 1'b0;
    abort    = 1'b0;
    if (newFrame && !final_beat) begin
      abort    = (state_q != IDLE);
      grid_clr = 1'b1;
      lead_d   = '0;
      if (leadDiscard == 0) begin
        state_d  = GRID;
        grid_inc = iValid;
      end else if (iValid && leadDiscard == 1) begin
        state_d = GRID;
      end else begin
        state_d = LEAD;
        lead_d  = iValid ? CNT_W'(1) : '0;
      end
    end else begin
      unique case (state_q)
        LEAD: begin
          if (iValid) begin
            if (lead_q == LEAD_LAST) begin
              state_d = GRID;
              lead_d  = '0;
            end else begin
              lead_d = lead_q + 1'b1;
            end
          end
        end
        GRID: begin
          grid_inc = iValid;
          if (final_beat)
            state_d = newFrame ? ((leadDiscard == 0) ? GRID : LEAD) : IDLE;
        end
        default: ;
      endcase
    end
  end

  assign interior = grid_inc && !grid_clr &&
                    (col >= B16) && (col < XEND) && (row >= B16) && (row < YEND);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      lead_q   <= '0;
      oValid_q <= 1'b0;
      oDone_q  <= 1'b0;
      oAbort_q <= 1'b0;
      oData_q  <= '0;
      oX_q     <= '0;
      oY_q     <= '0;
    end else begin
      state_q  <= state_d;
      lead_q   <= lead_d;
      oValid_q <= interior;
      oDone_q  <= interior && (col == XLAST) && (row == YLAST);
      oAbort_q <= abort;
      if (interior) begin
        oData_q <= iData;
        oX_q    <= col - B16;
        oY_q    <= row - B16;
      end
    end
  end

`ifdef FILTER_UNPAD_CHECKSUM_EN
  logic [31:0] sum_q;

  // Sum restarts at the first interior pixel so the previous total stays readable until then.
  always_ff @(posedge clk) begin
    if (!reset || abort) begin
      sum_q <= '0;
    end else if (interior) begin
      sum_q <= ((col == B16 && row == B16) ? 32'd0 : sum_q) + {8'b0, iData};
    end
  end

  assign oChecksum = sum_q;
`endif

  assign oValid = oValid_q;
  assign oData  = oData_q;
  assign oX     = oX_q;
  assign oY     = oY_q;
  assign oDone  = oDone_q;
  assign oAbort = oAbort_q;

endmodule

// File: tb/tb_filter_unpad.sv
// Scoreboard bench for filter_unpad on a 4x3 interior, 3x3 kernel grid (PW=6, PH=5).
module tb_filter_unpad;
  import isp_geom_pkg::*;

  typedef struct {
    logic [23:0] d;
    logic [15:0] x;
    logic [15:0] y;
    logic        done;
    logic [31:0] sum;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        nf0 = 1'b0, v0 = 1'b0, nf1 = 1'b0, v1 = 1'b0;
  logic [23:0] d0 = '0, d1 = '0;
  logic        ov0, od0, oa0, ov1, od1, oa1;
  logic [23:0] odata0, odata1;
  logic [15:0] ox0, oy0, ox1, oy1;
`ifdef FILTER_UNPAD_CHECKSUM_EN
  logic [31:0] cs0, cs1;
`endif

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  filter_unpad #(.width(4), .height(3), .kernelSize(3), .leadDiscard(0)) dut0 (
    .clk(clk), .reset(rst_n), .newFrame(nf0), .iValid(v0), .iData(d0),
    .oValid(ov0), .oData(odata0), .oX(ox0), .oY(oy0), .oDone(od0),
`ifdef FILTER_UNPAD_CHECKSUM_EN
    .oChecksum(cs0),
`endif
    .oAbort(oa0));

  filter_unpad #(.width(4), .height(3), .kernelSize(3), .leadDiscard(2)) dut1 (
    .clk(clk), .reset(rst_n), .newFrame(nf1), .iValid(v1), .iData(d1),
    .oValid(ov1), .oData(odata1), .oX(ox1), .oY(oy1), .oDone(od1),
`ifdef FILTER_UNPAD_CHECKSUM_EN
    .oChecksum(cs1),
`endif
    .oAbort(oa1));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_in(input int sel, input logic nf, input logic v, input logic [23:0] d);
    if (sel == 0) begin nf0 = nf; v0 = v; d0 = d; end
    else          begin nf1 = nf; v1 = v; d1 = d; end
  endtask

  // Pulses newFrame alone and checks the abort pulse that follows, then its return to 0.
  task automatic pulse(input int sel, input logic exp_abort);
    @(negedge clk); set_in(sel, 1'b1, 1'b0, '0);
    @(negedge clk); set_in(sel, 1'b0, 1'b0, '0);
    check($sformatf("abort%0d", sel), 64'(sel == 0 ? oa0 : oa1), 64'(exp_abort));
    @(negedge clk);
    check($sformatf("abort_clear%0d", sel), 64'(sel == 0 ? oa0 : oa1), 64'(0));
  endtask

  // Beat k carries iData=k; grid position is (k-lead) in raster order over the 6x5 grid.
  task automatic run_frame(input int sel, input int nbeats, input bit gap, input int lead);
    int   sum = 0;
    exp_t e;
    for (int k = 0; k < nbeats; k++) begin
      int g, r, c;
      @(negedge clk); set_in(sel, 1'b0, 1'b1, 24'(k));
      g = k - lead;
      r = g / 6;
      c = g % 6;
      if (g >= 0 && c >= 1 && c <= 4 && r >= 1 && r <= 3) begin
        sum += k;
        e.d = 24'(k); e.x = 16'(c - 1); e.y = 16'(r - 1);
        e.done = (c == 4 && r == 3); e.sum = 32'(sum); e.cyc = cyc + 1;
        if (sel == 0) q0.push_back(e); else q1.push_back(e);
      end
      if (gap) begin
        @(negedge clk); set_in(sel, 1'b0, 1'b0, '0);
      end
    end
    @(negedge clk); set_in(sel, 1'b0, 1'b0, '0);
  endtask

  task automatic compare(input int sel, input exp_t e, input logic [23:0] d, input logic [15:0] x,
                         input logic [15:0] y, input logic done, input logic [31:0] cs);
    check($sformatf("data%0d", sel), 64'(d), 64'(e.d));
    check($sformatf("x%0d", sel), 64'(x), 64'(e.x));
    check($sformatf("y%0d", sel), 64'(y), 64'(e.y));
    check($sformatf("done%0d", sel), 64'(done), 64'(e.done));
    check($sformatf("latency%0d", sel), 64'(cyc), 64'(e.cyc));
`ifdef FILTER_UNPAD_CHECKSUM_EN
    if (e.done) check($sformatf("checksum%0d", sel), 64'(cs), 64'(e.sum));
`else
    if (cs != 32'd0) check("checksum_tie", 64'(cs), 64'(0));
`endif
  endtask

  always @(negedge clk) begin
    logic [31:0] c0, c1;
`ifdef FILTER_UNPAD_CHECKSUM_EN
    c0 = cs0; c1 = cs1;
`else
    c0 = '0; c1 = '0;
`endif
    if (ov0 === 1'b1) begin
      if (q0.size() == 0) check("unexpected_out0", 64'(odata0), 64'hFFFF_FFFF);
      else compare(0, q0.pop_front(), odata0, ox0, oy0, od0, c0);
    end else if (od0 === 1'b1) check("done_without_valid0", 64'(od0), 64'(0));
    if (ov1 === 1'b1) begin
      if (q1.size() == 0) check("unexpected_out1", 64'(odata1), 64'hFFFF_FFFF);
      else compare(1, q1.pop_front(), odata1, ox1, oy1, od1, c1);
    end else if (od1 === 1'b1) check("done_without_valid1", 64'(od1), 64'(0));
  end

  task automatic check_reset_outputs();
    check("rst_valid", 64'({ov0, ov1}), 64'(0));
    check("rst_data", 64'({odata0, odata1}), 64'(0));
    check("rst_xy", 64'({ox0, oy0, ox1, oy1}), 64'(0));
    check("rst_done_abort", 64'({od0, oa0, od1, oa1}), 64'(0));
  endtask

  task automatic idle_beats(input int sel);
    check($sformatf("state_idle%0d", sel),
          64'(sel == 0 ? dut0.state_q : dut1.state_q), 64'(IDLE));
    repeat (3) begin
      @(negedge clk); set_in(sel, 1'b0, 1'b1, 24'hABCDEF);
    end
    @(negedge clk); set_in(sel, 1'b0, 1'b0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;

    // back-to-back frame, then iValid in IDLE must be ignored
    pulse(0, 1'b0);
    run_frame(0, 30, 1'b0, 0);
    idle_beats(0);

    // every-other-cycle gaps
    pulse(0, 1'b0);
    run_frame(0, 30, 1'b1, 0);
    idle_beats(0);

    // two lead-in beats discarded
    pulse(1, 1'b0);
    run_frame(1, 32, 1'b0, 2);
    idle_beats(1);

    // abort after beat 10, then a full frame
    pulse(0, 1'b0);
    run_frame(0, 11, 1'b0, 0);
    pulse(0, 1'b1);
    run_frame(0, 30, 1'b0, 0);
    idle_beats(0);

    // reset mid-grid, then restart
    pulse(0, 1'b0);
    run_frame(0, 15, 1'b0, 0);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); check_reset_outputs();
    rst_n = 1'b1;
    check("state_after_reset", 64'(dut0.state_q), 64'(IDLE));
    pulse(0, 1'b0);
    run_frame(0, 30, 1'b0, 0);
    idle_beats(0);

    repeat (4) @(negedge clk);
    check("queue0_drained", 64'(q0.size()), 64'(0));
    check("queue1_drained", 64'(q1.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/filter_unpad.md
Name: filter_unpad

Overview:
- Receive-side counterpart of the boundary-padding stage in front of the filter.
- Consumes the filter's output stream laid out on the padded raster grid:
  - padded width PW = width + 2*B
  - padded height PH = height + 2*B
  - B = (kernelSize-1)/2
- Discards all border and pipeline-fill beats. Emits only the width x height interior pixels in raster order, with x/y coordinates and a frame-done pulse.
- Sits between filter_fifo and the colour-space stage.

Parameters:
- width, 320, interior pixels per row
- height, 240, interior rows per frame
- kernelSize, 3, filter kernel size (odd, >=3); sets B
- leadDiscard, 0, valid beats dropped at frame start before grid position (0,0)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- newFrame  in  1  one-cycle pulse; arms capture of the next frame
- iValid  in  1  one padded-grid beat present
- iData  in  24  {R,G,B} for that beat
- oValid  out  1  interior pixel present
- oData  out  24  interior pixel {R,G,B}
- oX  out  16  interior column 0..width-1
- oY  out  16  interior row 0..height-1
- oDone  out  1  one-cycle pulse with the last interior pixel
- oAbort  out  1  one-cycle pulse: frame abandoned by newFrame mid-frame

Behaviour:
- Reset (reset==0 at a clk edge): all outputs 0; state IDLE; all counters 0.
- States:
  - IDLE → LEAD on newFrame when leadDiscard>0.
  - IDLE → GRID on newFrame when leadDiscard==0.
  - LEAD: counts iValid beats. → GRID after leadDiscard beats.
  - GRID: col counter 0..PW-1 and row counter 0..PH-1 advance only on iValid. col wraps to 0 and row increments at col==PW-1.
  - GRID → IDLE on the beat at col==PW-1 and row==PH-1.
- A beat is interior iff B<=col<B+width and B<=row<B+height.
- Output on an interior beat, one cycle after the iValid beat (registered latency 1):
  - oValid=1
  - oData=iData
  - oX=col-B
  - oY=row-B
- Non-interior and LEAD beats produce oValid=0. oData and oX/oY hold their last values.
- oDone=1 together with oValid for interior pixel (width-1,height-1).
  - The trailing bottom border (B rows plus tail) is still consumed in GRID before returning to IDLE.
  - oDone is not delayed to frame end.
- iValid in IDLE: ignored, no output.
- newFrame in LEAD or GRID:
  - oAbort pulses the next cycle.
  - Counters clear; re-enter LEAD/GRID as from IDLE.
  - The same-cycle iValid beat is counted as the first beat of the new frame.
- newFrame on the final GRID beat: the final beat completes normally (oDone if applicable); the new frame is armed; no oAbort.
- iValid gaps of any length: allowed; counters hold.
- Counter widths: 16 bits; width+2B and height+2B must be < 65536.

Optional Feature:
- Macro: FILTER_UNPAD_CHECKSUM_EN.
- With the macro defined:
  - Adds output oChecksum (32 bits).
  - Holds the modulo-2^32 sum of {8'b0,oData} over all interior pixels of the frame.
  - Valid in the cycle oDone pulses; held until the next frame's first interior pixel.
  - Cleared on reset and on abort.
- Without the macro: no port, no adder logic.

Decomposition:
- Package isp_geom_pkg:
  - localparam functions for B, PW, PH and total beats PW*PH+leadDiscard
  - state enum {IDLE, LEAD, GRID}
  - pixel width constant 24
- Sub-module raster_counter:
  - parameterised cols/rows
  - inc, clr inputs
  - col, row, last outputs
- raster_counter is reused by padding-side logic.

Test Plan (width=4, height=3, kernelSize=3 → B=1, PW=6, PH=5):
- newFrame then 30 back-to-back beats with iData=beat index → exactly 12 oValid.
  - First output: oData=7, oX=0, oY=0.
  - Last output: oData=22, oX=3, oY=2, with oDone=1.
  - Return to IDLE after beat 29.
- Same stimulus with iValid deasserted every other cycle → identical 12 outputs; each output one cycle after its beat.
- leadDiscard=2: 32 beats with values 0..31 → first output oData=9; last output oData=24 with oDone.
- newFrame after beat 10, then a full 30-beat frame → oAbort one pulse; next frame produces the full 12 outputs from (0,0).
- reset low mid-GRID, then release and restart the frame → all outputs 0 during reset; the new frame outputs normally.
- Checksum feature on, frame of 30 beats with iData=beat index → oChecksum=174 on oDone.
